// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: HD44780 character-LCD bus controller.
//
// Turns single host strobes (nCS/nWR/nRD/RS) into timed LCD bus cycles. It
// owns the LCD data bus, including the output enable and read capture. Each
// byte, or each nibble in 4-bit mode, runs the phases SETUP, PULSE, HOLD and
// GAP, so consecutive EN rises are at least T_CYC cycles apart. After a write
// it can poll the busy flag, with a bound on the number of polls.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   nCS, nWR, nRD   host strobes, active low
//   RS, DIN         host register select and write data, latched at accept
//   DOUT            read data, valid while RDY=1 after a read
//   RDY             1 = idle, last transaction complete
//   TOERR           sticky busy-poll timeout, cleared at the next accept
//   LCD_RS, LCD_RW  LCD register select and read/write (1 = read)
//   LCD_EN          LCD enable strobe
//   LCD_DB_O/_I/_OE LCD data bus out, in and drive enable
module lcd_bus_ctrl #(
  parameter int unsigned MODE_4BIT = 0,
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_PW      = 12,
  parameter int unsigned T_H       = 1,
  parameter int unsigned T_CYC     = 26,
  parameter int unsigned BUSY_POLL = 1,
  parameter int unsigned BUSY_TO   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       nWR,
  input  logic       nRD,
  input  logic       RS,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       RDY,
  output logic       TOERR,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DB_O,
  input  logic [7:0] LCD_DB_I,
  output logic       LCD_DB_OE
);

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxParam =
    maxOf(maxOf(maxOf(T_AS, T_PW), maxOf(T_H, T_CYC)), BUSY_TO);
  localparam int unsigned CW = $clog2(MaxParam) + 1;

  // When another phase follows, its SETUP sits inside the T_CYC window, so
  // the gap is shortened by T_AS. That keeps the EN-to-EN spacing at exactly
  // T_CYC.
  localparam int unsigned ContGap = T_CYC - T_PW - T_H - T_AS;
  localparam int unsigned FinGap  = T_CYC - T_PW - T_H;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pollCnt;
  logic          nib;       // 0 = high nibble (or the whole byte), 1 = low nibble
  logic          polling;   // currently running busy-flag status reads
  logic          armed;     // host must release nCS before the next accept
  logic          reqRs;
  logic          reqRw;
  logic [7:0]    reqData;
  logic [7:0]    cap;
  logic          cont;      // a further phase follows the current GAP
  logic          finTo;     // finishing this GAP ends a timed-out poll sequence
  logic          finRead;   // finishing this GAP completes a host read
  logic          rdyQ;
  logic          toErrQ;
  logic [7:0]    doutQ;

  logic          accept;
  logic          busRs;
  logic          busRw;
  logic          lastNib;
  logic          startPoll;
  logic          pollAgain;
  logic          moreHold;
  logic          setupDone;
  logic          pulseDone;
  logic          holdDone;
  logic          gapDone;
  logic          busActive;
  int unsigned   gapLen;

  always_comb begin
    accept    = (state == IDLE) && armed && !nCS && (nWR ^ nRD);
    busRs     = polling ? 1'b0 : reqRs;
    busRw     = polling ? 1'b1 : reqRw;
    lastNib   = (MODE_4BIT == 0) || nib;
    startPoll = !polling && !reqRw && (BUSY_POLL != 0);
    // cap[7] comes from the first (high) nibble, so it is valid here for both modes
    pollAgain = polling && cap[7] && ((32'(pollCnt) + 32'd1) < BUSY_TO);
    moreHold  = !lastNib || startPoll || pollAgain;
    gapLen    = cont ? ContGap : FinGap;
    setupDone = (32'(cnt) == T_AS - 1);
    pulseDone = (32'(cnt) == T_PW - 1);
    holdDone  = (32'(cnt) == T_H - 1);
    gapDone   = (32'(cnt) == gapLen - 1);
    busActive = (state == SETUP) || (state == PULSE) || (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pollCnt <= '0;
      nib     <= 1'b0;
      polling <= 1'b0;
      armed   <= 1'b1;
      reqRs   <= 1'b0;
      reqRw   <= 1'b0;
      reqData <= 8'h00;
      cap     <= 8'h00;
      cont    <= 1'b0;
      finTo   <= 1'b0;
      finRead <= 1'b0;
      rdyQ    <= 1'b1;
      toErrQ  <= 1'b0;
      doutQ   <= 8'h00;
    end else begin
      if (accept) begin
        armed <= 1'b0;
      end else if (nCS) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            reqRs   <= RS;
            reqRw   <= nWR;  // nWR high here means nRD is the low strobe
            reqData <= DIN;
            rdyQ    <= 1'b0;
            toErrQ  <= 1'b0;
            nib     <= 1'b0;
            polling <= 1'b0;
            pollCnt <= '0;
            cnt     <= '0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (setupDone) begin
            cnt   <= '0;
            state <= PULSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PULSE: begin
          if (pulseDone) begin
            cnt   <= '0;
            state <= HOLD;
            if (busRw) begin
              if (MODE_4BIT != 0) begin
                if (nib) begin
                  cap[3:0] <= LCD_DB_I[7:4];
                end else begin
                  cap[7:4] <= LCD_DB_I[7:4];
                end
              end else begin
                cap <= LCD_DB_I;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (holdDone) begin
            cnt     <= '0;
            cont    <= moreHold;
            finTo   <= polling && cap[7];
            finRead <= !polling && reqRw;
            if (!lastNib) begin
              nib <= 1'b1;
            end else if (startPoll) begin
              polling <= 1'b1;
              nib     <= 1'b0;
            end else if (pollAgain) begin
              pollCnt <= pollCnt + 1'b1;
              nib     <= 1'b0;
            end
            state <= (moreHold && (ContGap == 0)) ? SETUP : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (gapDone) begin
            cnt <= '0;
            if (cont) begin
              state <= SETUP;
            end else begin
              state <= IDLE;
              rdyQ  <= 1'b1;
              if (finTo) begin
                toErrQ <= 1'b1;
              end
              if (finRead) begin
                doutQ <= cap;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from state, so an asynchronous reset drops EN at once.
  always_comb begin
    RDY       = rdyQ;
    TOERR     = toErrQ;
    DOUT      = doutQ;
    LCD_EN    = (state == PULSE);
    LCD_RS    = (state != IDLE) && busRs;
    LCD_RW    = (state != IDLE) && busRw;
    LCD_DB_OE = busActive && !busRw;
    LCD_DB_O  = 8'h00;
    if (LCD_DB_OE) begin
      if (MODE_4BIT != 0) begin
        LCD_DB_O = nib ? {reqData[3:0], 4'h0} : {reqData[7:4], 4'h0};
      end else begin
        LCD_DB_O = reqData;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
`timescale 1ns/1ps
module tb_lcd_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nWR = 1'b1;
  logic nRD = 1'b1;
  logic RS  = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic cs8 = 1'b1;
  logic cs4 = 1'b1;
  logic csP = 1'b1;
  logic [7:0] dbi8 = 8'h00;
  logic [7:0] dbi4 = 8'h00;
  logic [7:0] dbiP = 8'h00;

  logic [7:0] dout8, dbo8, dout4, dbo4, doutP, dboP;
  logic rdy8, to8, rs8, rw8, en8, oe8;
  logic rdy4, to4, rs4, rw4, en4, oe4;
  logic rdyP, toP, rsP, rwP, enP, oeP;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_bus_ctrl #(.MODE_4BIT(0), .BUSY_POLL(0)) dut8 (
    .clk(clk), .rst(rst), .nCS(cs8), .nWR(nWR), .nRD(nRD), .RS(RS), .DIN(DIN),
    .DOUT(dout8), .RDY(rdy8), .TOERR(to8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_EN(en8),
    .LCD_DB_O(dbo8), .LCD_DB_I(dbi8), .LCD_DB_OE(oe8)
  );

  lcd_bus_ctrl #(.MODE_4BIT(1), .BUSY_POLL(0)) dut4 (
    .clk(clk), .rst(rst), .nCS(cs4), .nWR(nWR), .nRD(nRD), .RS(RS), .DIN(DIN),
    .DOUT(dout4), .RDY(rdy4), .TOERR(to4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_EN(en4),
    .LCD_DB_O(dbo4), .LCD_DB_I(dbi4), .LCD_DB_OE(oe4)
  );

  lcd_bus_ctrl #(.MODE_4BIT(0), .BUSY_POLL(1), .BUSY_TO(4)) dutP (
    .clk(clk), .rst(rst), .nCS(csP), .nWR(nWR), .nRD(nRD), .RS(RS), .DIN(DIN),
    .DOUT(doutP), .RDY(rdyP), .TOERR(toP), .LCD_RS(rsP), .LCD_RW(rwP), .LCD_EN(enP),
    .LCD_DB_O(dboP), .LCD_DB_I(dbiP), .LCD_DB_OE(oeP)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic releaseBus();
    cs8 = 1'b1;
    cs4 = 1'b1;
    csP = 1'b1;
    nWR = 1'b1;
    nRD = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 8;
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset RDY got %b exp 1", rdy8); end
    if (to8 !== 1'b0) begin errors++; $display("FAIL reset TOERR got %b exp 0", to8); end
    if (dout8 !== 8'h00) begin errors++; $display("FAIL reset DOUT got %h exp 00", dout8); end
    if (en8 !== 1'b0) begin errors++; $display("FAIL reset EN got %b exp 0", en8); end
    if (oe8 !== 1'b0) begin errors++; $display("FAIL reset OE got %b exp 0", oe8); end
    if (dbo8 !== 8'h00) begin errors++; $display("FAIL reset DB_O got %h exp 00", dbo8); end
    if (rw8 !== 1'b0) begin errors++; $display("FAIL reset RW got %b exp 0", rw8); end
    if (rs8 !== 1'b0) begin errors++; $display("FAIL reset LCD_RS got %b exp 0", rs8); end
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_write8();
    logic expEn, expOe, expRdy;
    cs8 = 1'b0; nWR = 1'b0; RS = 1'b1; DIN = 8'h41;
    step();
    releaseBus();
    DIN = 8'hFF;  // must not reach the bus: data was latched at accept
    for (int c = 1; c <= 32; c++) begin
      expEn  = (c >= 3) && (c <= 14);
      expOe  = (c <= 15);
      expRdy = (c >= 29);
      checks += 3;
      if (en8 !== expEn) begin errors++; $display("FAIL write8 EN c=%0d got %b exp %b", c, en8, expEn); end
      if (oe8 !== expOe) begin errors++; $display("FAIL write8 OE c=%0d got %b exp %b", c, oe8, expOe); end
      if (rdy8 !== expRdy) begin errors++; $display("FAIL write8 RDY c=%0d got %b exp %b", c, rdy8, expRdy); end
      if (c == 1 || c == 15) begin
        checks += 3;
        if (dbo8 !== 8'h41) begin errors++; $display("FAIL write8 DB_O c=%0d got %h exp 41", c, dbo8); end
        if (rs8 !== 1'b1) begin errors++; $display("FAIL write8 LCD_RS c=%0d got %b exp 1", c, rs8); end
        if (rw8 !== 1'b0) begin errors++; $display("FAIL write8 RW c=%0d got %b exp 0", c, rw8); end
      end
      step();
    end
  endtask

  task automatic test_read8();
    logic expRdy;
    cs8 = 1'b0; nRD = 1'b0; RS = 1'b1; dbi8 = 8'h5A;
    step();
    releaseBus();
    for (int c = 1; c <= 30; c++) begin
      expRdy = (c >= 29);
      checks += 2;
      if (oe8 !== 1'b0) begin errors++; $display("FAIL read8 OE c=%0d got %b exp 0", c, oe8); end
      if (rdy8 !== expRdy) begin errors++; $display("FAIL read8 RDY c=%0d got %b exp %b", c, rdy8, expRdy); end
      if (c <= 15) begin
        checks += 2;
        if (rw8 !== 1'b1) begin errors++; $display("FAIL read8 RW c=%0d got %b exp 1", c, rw8); end
        if (rs8 !== 1'b1) begin errors++; $display("FAIL read8 LCD_RS c=%0d got %b exp 1", c, rs8); end
      end
      if (c == 29) begin
        checks++;
        if (dout8 !== 8'h5A) begin errors++; $display("FAIL read8 DOUT got %h exp 5a", dout8); end
      end
      step();
    end
  endtask

  task automatic test_write4();
    logic expEn, expOe, expRdy;
    logic [7:0] expDb;
    cs4 = 1'b0; nWR = 1'b0; RS = 1'b0; DIN = 8'hC3;
    step();
    releaseBus();
    for (int c = 1; c <= 58; c++) begin
      expEn  = ((c >= 3) && (c <= 14)) || ((c >= 29) && (c <= 40));
      expOe  = (c <= 15) || ((c >= 27) && (c <= 41));
      expRdy = (c >= 55);
      expDb  = (c <= 15) ? 8'hC0 : (((c >= 27) && (c <= 41)) ? 8'h30 : 8'h00);
      checks += 4;
      if (en4 !== expEn) begin errors++; $display("FAIL write4 EN c=%0d got %b exp %b", c, en4, expEn); end
      if (oe4 !== expOe) begin errors++; $display("FAIL write4 OE c=%0d got %b exp %b", c, oe4, expOe); end
      if (dbo4 !== expDb) begin errors++; $display("FAIL write4 DB_O c=%0d got %h exp %h", c, dbo4, expDb); end
      if (rdy4 !== expRdy) begin errors++; $display("FAIL write4 RDY c=%0d got %b exp %b", c, rdy4, expRdy); end
      step();
    end
  endtask

  // Write on the polling instance, then count status reads until RDY returns.
  // busyPolls = number of polls answered with bit7=1 before bit7 drops.
  task automatic runPolledWrite(input int busyPolls, output int polls, output int rdyCyc);
    logic prevEn;
    bit seenWrite;
    polls = 0; rdyCyc = 0; prevEn = 1'b0; seenWrite = 0;
    dbiP = 8'h80;
    csP = 1'b0; nWR = 1'b0; RS = 1'b1; DIN = 8'h01;
    step();
    releaseBus();
    for (int c = 1; c <= 400; c++) begin
      if (enP && !prevEn) begin
        if (!seenWrite) begin
          seenWrite = 1;
          checks++;
          if (rwP !== 1'b0) begin errors++; $display("FAIL poll write pulse RW got %b exp 0", rwP); end
        end else begin
          polls++;
          checks += 3;
          if (rsP !== 1'b0) begin errors++; $display("FAIL poll %0d LCD_RS got %b exp 0", polls, rsP); end
          if (rwP !== 1'b1) begin errors++; $display("FAIL poll %0d RW got %b exp 1", polls, rwP); end
          if (oeP !== 1'b0) begin errors++; $display("FAIL poll %0d OE got %b exp 0", polls, oeP); end
          dbiP = (polls <= busyPolls) ? 8'h80 : 8'h00;
        end
      end
      prevEn = enP;
      if (rdyP) begin
        rdyCyc = c;
        break;
      end
      step();
    end
    checks++;
    if (rdyCyc == 0) begin errors++; $display("FAIL poll RDY never returned got 0 exp 1"); end
  endtask

  task automatic test_busy_poll();
    int polls, rdyCyc;
    runPolledWrite(2, polls, rdyCyc);
    checks += 4;
    if (polls !== 3) begin errors++; $display("FAIL busy_poll count got %0d exp 3", polls); end
    if (rdyCyc !== 107) begin errors++; $display("FAIL busy_poll RDY cycle got %0d exp 107", rdyCyc); end
    if (toP !== 1'b0) begin errors++; $display("FAIL busy_poll TOERR got %b exp 0", toP); end
    if (doutP !== 8'h00) begin errors++; $display("FAIL busy_poll DOUT got %h exp 00", doutP); end
    step();
  endtask

  task automatic test_timeout();
    int polls, rdyCyc, waitCyc;
    runPolledWrite(1000, polls, rdyCyc);
    checks += 3;
    if (polls !== 4) begin errors++; $display("FAIL timeout count got %0d exp 4", polls); end
    if (rdyCyc !== 133) begin errors++; $display("FAIL timeout RDY cycle got %0d exp 133", rdyCyc); end
    if (toP !== 1'b1) begin errors++; $display("FAIL timeout TOERR got %b exp 1", toP); end
    step();
    // A following read clears TOERR at accept and does not poll.
    dbiP = 8'h80;
    csP = 1'b0; nRD = 1'b0; RS = 1'b0;
    step();
    releaseBus();
    checks += 2;
    if (toP !== 1'b0) begin errors++; $display("FAIL timeout clear TOERR got %b exp 0", toP); end
    if (rdyP !== 1'b0) begin errors++; $display("FAIL timeout clear RDY got %b exp 0", rdyP); end
    waitCyc = 0;
    while (!rdyP && waitCyc < 60) begin
      step();
      waitCyc++;
    end
    checks += 3;
    if (rdyP !== 1'b1) begin errors++; $display("FAIL timeout read RDY got %b exp 1", rdyP); end
    if (doutP !== 8'h80) begin errors++; $display("FAIL timeout read DOUT got %h exp 80", doutP); end
    if (toP !== 1'b0) begin errors++; $display("FAIL timeout read TOERR got %b exp 0", toP); end
    step();
  endtask

  task automatic test_hold_strobe();
    int rises;
    logic prevEn;
    rises = 0; prevEn = 1'b0;
    cs8 = 1'b0; nWR = 1'b0; RS = 1'b0; DIN = 8'h38;
    for (int c = 0; c < 100; c++) begin
      step();
      if (en8 && !prevEn) rises++;
      prevEn = en8;
    end
    releaseBus();
    for (int c = 0; c < 3; c++) begin
      step();
      if (en8 && !prevEn) rises++;
      prevEn = en8;
    end
    checks += 2;
    if (rises !== 1) begin errors++; $display("FAIL hold_strobe EN pulses got %0d exp 1", rises); end
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL hold_strobe RDY got %b exp 1", rdy8); end
  endtask

  task automatic test_illegal();
    int enCyc, busyCyc;
    enCyc = 0; busyCyc = 0;
    cs8 = 1'b0; nWR = 1'b0; nRD = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (en8) enCyc++;
      if (!rdy8) busyCyc++;
    end
    releaseBus();
    step();
    checks += 2;
    if (enCyc !== 0) begin errors++; $display("FAIL illegal EN cycles got %0d exp 0", enCyc); end
    if (busyCyc !== 0) begin errors++; $display("FAIL illegal RDY-low cycles got %0d exp 0", busyCyc); end
  endtask

  task automatic test_reset_pulse();
    cs8 = 1'b0; nWR = 1'b0; RS = 1'b1; DIN = 8'h55;
    step();
    releaseBus();
    for (int c = 1; c < 6; c++) step();
    checks++;
    if (en8 !== 1'b1) begin errors++; $display("FAIL rst_pulse EN before reset got %b exp 1", en8); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (en8 !== 1'b0) begin errors++; $display("FAIL rst_pulse EN got %b exp 0", en8); end
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL rst_pulse RDY got %b exp 1", rdy8); end
    if (oe8 !== 1'b0) begin errors++; $display("FAIL rst_pulse OE got %b exp 0", oe8); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks += 2;
    if (en8 !== 1'b0) begin errors++; $display("FAIL rst_pulse EN after release got %b exp 0", en8); end
    if (rdy8 !== 1'b1) begin errors++; $display("FAIL rst_pulse RDY after release got %b exp 1", rdy8); end
  endtask

  initial begin
    test_reset();
    test_write8();
    test_read8();
    test_write4();
    test_busy_poll();
    test_timeout();
    test_hold_strobe();
    test_illegal();
    test_reset_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
